// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fib_pkg
//  Description : Shared definitions for the Fibonacci engines (forward
//                generator and inverse search). Holds the common command
//                state encoding and the two seed values of the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

    // Command state machine shared by the forward and inverse engines.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } fib_state_t;

    // Seeds of the sequence: F(0)=0, F(1)=1.
    localparam int unsigned C_FIB_0 = 0;
    localparam int unsigned C_FIB_1 = 1;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_index.sv
`default_nettype none
// ============================================================================
//  Module      : fib_index
//  Description : Inverse Fibonacci search. For an unsigned value N, walks the
//                sequence F(0)=0, F(1)=1, ... and reports the largest index k
//                with F(k) <= N, the value F(k), and whether F(k) == N.
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous, active-low reset
//                start     - command strobe, honoured only in IDLE or DONE
//                din       - value N, captured on the accepted start edge
//                idx       - largest k with F(k) <= N
//                fib_floor - F(idx)
//                exact     - 1 when fib_floor == N
//                busy      - high while the search is running
//                done      - high once a result is ready, until next start
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_index
    import fib_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] fib_floor,
    output logic             exact,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] C_IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    fib_state_t       r_state;
    logic [WIDTH-1:0] r_n;      // latched target value N
    logic [WIDTH-1:0] r_a;      // F(k)
    logic [WIDTH:0]   r_b;      // F(k+1); extra bit catches the terminal carry
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_fib;
    logic             r_exact;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    fib_state_t       w_state_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH:0]   w_b_nxt;
    logic [IDX_W-1:0] w_k_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_fib_nxt;
    logic             w_exact_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_b_past_n;

    // A set carry bit always exceeds a WIDTH-bit N, so the overflow stop falls
    // out of the same comparison.
    assign w_b_past_n = (r_b > {1'b0, r_n});

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_k_nxt     = r_k;
        w_idx_nxt   = r_idx;
        w_fib_nxt   = r_fib;
        w_exact_nxt = r_exact;
        w_done_nxt  = r_done;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_n_nxt     = din;
                    w_a_nxt     = WIDTH'(C_FIB_0);
                    w_b_nxt     = (WIDTH+1)'(C_FIB_1);
                    w_k_nxt     = '0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_b_past_n) begin
                    w_idx_nxt   = r_k;
                    w_fib_nxt   = r_a;
                    w_exact_nxt = (r_a == r_n);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    // b <= N here, so b fits in WIDTH bits and a+b cannot wrap.
                    w_a_nxt = r_b[WIDTH-1:0];
                    w_b_nxt = {1'b0, r_a} + r_b;
                    w_k_nxt = r_k + C_IDX_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_SEARCH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_idx   <= '0;
            r_fib   <= '0;
            r_exact <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_k     <= w_k_nxt;
            r_idx   <= w_idx_nxt;
            r_fib   <= w_fib_nxt;
            r_exact <= w_exact_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign idx       = r_idx;
    assign fib_floor = r_fib;
    assign exact     = r_exact;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : fib_index
`default_nettype wire

// File: tb/tb_fib_index.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_index
//  Description : Self-checking bench for fib_index: directed table, corner
//                sequences (start ignored mid-search, reset mid-search,
//                result hold in DONE) and random values against a lookup of
//                the Fibonacci table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_index;

    localparam int WIDTH = 16;
    localparam int IDX_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] din;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] fib_floor;
    logic             exact;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    fib_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .idx       (idx),
        .fib_floor (fib_floor),
        .exact     (exact),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned n;
        int unsigned e_idx;
        int unsigned e_fib;
        bit          e_exact;
    } vec_t;

    vec_t        vecs [12];
    int unsigned fib_tab [26];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Largest k with F(k) <= n, scanning the table from the top.
    function automatic int unsigned ref_idx(input int unsigned n);
        for (int k = 25; k >= 0; k--)
            if (fib_tab[k] <= n) return k;
        return 0;
    endfunction

    // Start a job; optionally re-pulse start with a different din after
    // 'poke' cycles. Waits for done and checks result and latency.
    task automatic run_job(input int unsigned n, input int unsigned e_idx,
                           input int unsigned e_fib, input bit e_exact,
                           input int poke, input string tag);
        int edges;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        din   = n[WIDTH-1:0];
        @(negedge clk);
        start = 1'b0;
        din   = $urandom_range(0, 65535);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (poke > 0 && edges == poke) begin
                start = 1'b1;
                din   = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk({tag, " latency"}, edges, e_idx + 1);
        chk({tag, " busy_cycles"}, busy_cnt, e_idx + 1);
        chk({tag, " busy_low"}, busy, 0);
        chk({tag, " idx"}, idx, e_idx);
        chk({tag, " fib_floor"}, fib_floor, e_fib);
        chk({tag, " exact"}, exact, e_exact);
    endtask

    initial begin
        int unsigned rn;
        int unsigned rk;
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        din      = '0;
        reset    = 1'b0;

        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int k = 2; k < 26; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];

        vecs[0]  = '{0,     0,  0,     1'b1};
        vecs[1]  = '{1,     2,  1,     1'b1};
        vecs[2]  = '{100,   11, 89,    1'b0};
        vecs[3]  = '{144,   12, 144,   1'b1};
        vecs[4]  = '{65535, 24, 46368, 1'b0};
        vecs[5]  = '{46368, 24, 46368, 1'b1};
        vecs[6]  = '{2,     3,  2,     1'b1};
        vecs[7]  = '{3,     4,  3,     1'b1};
        vecs[8]  = '{4,     4,  3,     1'b0};
        vecs[9]  = '{5,     5,  5,     1'b1};
        vecs[10] = '{89,    11, 89,    1'b1};
        vecs[11] = '{90,    11, 89,    1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset idx", idx, 0);
        chk("reset fib_floor", fib_floor, 0);
        chk("reset exact", exact, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        // Directed table; consecutive jobs start straight from DONE.
        foreach (vecs[i])
            run_job(vecs[i].n, vecs[i].e_idx, vecs[i].e_fib, vecs[i].e_exact,
                    0, $sformatf("vec%0d", i));

        // DONE holds with start low.
        repeat (3) @(negedge clk);
        chk("hold done", done, 1);
        chk("hold idx", idx, 11);
        chk("hold fib_floor", fib_floor, 89);
        chk("hold busy", busy, 0);

        // Start re-pulsed mid-search with a different din is ignored.
        run_job(1000, 16, 987, 1'b0, 3, "ignore_start");

        // Reset in the middle of a search.
        @(negedge clk);
        start = 1'b1;
        din   = 16'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset idx", idx, 0);
        chk("midreset fib_floor", fib_floor, 0);
        chk("midreset exact", exact, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        @(negedge clk);
        chk("midreset stays idle", busy, 0);
        run_job(8, 6, 8, 1'b1, 0, "after_reset");

        // Random values against the table lookup.
        for (int r = 0; r < 30; r++) begin
            case (r % 3)
                0:       rn = $urandom_range(0, 65535);
                1:       rn = $urandom_range(0, 200);
                default: rn = fib_tab[$urandom_range(0, 24)];
            endcase
            rk = ref_idx(rn);
            run_job(rn, rk, fib_tab[rk], (fib_tab[rk] == rn), 0,
                    $sformatf("rand%0d n=%0d", r, rn));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fib_index
`default_nettype wire
